// File: rtl/display_formatter.sv
// display_formatter: signed 16-bit value -> four seven-segment patterns.
// Sequential double-dabble over 16 cycles, then sign / leading-zero
// handling and segment encoding. All four patterns update on one edge.
module display_formatter #(
  parameter bit LZB = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] value,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [0:7]  oct0,
  output logic [0:7]  oct1,
  output logic [0:7]  oct2,
  output logic [0:7]  oct3
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_ENC   = 2'd2;

  localparam logic [0:7] SEG_MINUS = 8'b00000010;
  localparam logic [0:7] SEG_E     = 8'b10011110;
  localparam logic [0:7] SEG_BLANK = 8'b00000000;

  logic [1:0]  r_state;
  logic        r_neg;
  logic        r_ovf;
  logic [15:0] r_mag;
  logic [15:0] r_bcd;
  logic [4:0]  r_cnt;
  logic        r_done;
  logic [0:7]  r_oct [4];

  logic [15:0] w_mag;
  logic        w_ovf;
  logic [15:0] w_adj;
  logic [3:0]  w_dig [4];
  logic [0:4]  w_lead;
  logic [0:7]  w_pat [4];

  // Digit -> segments, bit 0 = segment a
  function automatic logic [0:7] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_seg = 8'b11111100;
      4'd1:    f_seg = 8'b01100000;
      4'd2:    f_seg = 8'b11011010;
      4'd3:    f_seg = 8'b11110010;
      4'd4:    f_seg = 8'b01100110;
      4'd5:    f_seg = 8'b10110110;
      4'd6:    f_seg = 8'b10111110;
      4'd7:    f_seg = 8'b11100000;
      4'd8:    f_seg = 8'b11111110;
      4'd9:    f_seg = 8'b11110110;
      default: f_seg = SEG_BLANK;
    endcase
  endfunction

  // Magnitude and overflow of the incoming value (-32768 maps to 32768)
  always_comb begin
    w_mag = value[15] ? (~value + 16'd1) : value;
    w_ovf = value[15] ? (w_mag > 16'd999) : (w_mag > 16'd9999);
  end

  // Add-3 correction on every BCD nibble that is 5 or more
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 4; i++)
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
  end

  // Leading-zero flags: w_lead[i] means digits 0..i are all zero.
  // The units digit never counts as leading, so minus always has a slot.
  always_comb begin
    for (int i = 0; i < 4; i++) w_dig[i] = r_bcd[15 - 4*i -: 4];
    w_lead    = '0;
    w_lead[0] = (w_dig[0] == 4'd0);
    w_lead[1] = w_lead[0] && (w_dig[1] == 4'd0);
    w_lead[2] = w_lead[1] && (w_dig[2] == 4'd0);
  end

  // Pattern formation: overflow, zero-pad, or blanked with floating minus
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_pat[i] = f_seg(w_dig[i]);
      if (r_ovf)
        w_pat[i] = SEG_E;
      else if (!LZB) begin
        if (r_neg && i == 0) w_pat[i] = SEG_MINUS;
      end else if (w_lead[i])
        w_pat[i] = (r_neg && !w_lead[i+1]) ? SEG_MINUS : SEG_BLANK;
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_neg   <= 1'b0;
      r_ovf   <= 1'b0;
      r_mag   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      for (int i = 0; i < 4; i++) r_oct[i] <= SEG_BLANK;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (load) begin
          r_neg   <= value[15];
          r_mag   <= w_mag;
          r_ovf   <= w_ovf;
          r_bcd   <= '0;
          r_cnt   <= '0;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          r_bcd <= {w_adj[14:0], r_mag[15]};
          r_mag <= {r_mag[14:0], 1'b0};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd15) r_state <= S_ENC;
        end
        S_ENC: begin
          for (int i = 0; i < 4; i++) r_oct[i] <= w_pat[i];
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign oct0 = r_oct[0];
  assign oct1 = r_oct[1];
  assign oct2 = r_oct[2];
  assign oct3 = r_oct[3];

endmodule

// File: tb/tb_display_formatter.sv
// Directed + random bench for display_formatter, both LZB settings in parallel.
module tb_display_formatter;

  localparam logic [7:0] S0 = 8'b11111100, S1 = 8'b01100000, S2 = 8'b11011010;
  localparam logic [7:0] S3 = 8'b11110010, S4 = 8'b01100110, S5 = 8'b10110110;
  localparam logic [7:0] S6 = 8'b10111110, S7 = 8'b11100000, S8 = 8'b11111110;
  localparam logic [7:0] S9 = 8'b11110110, SM = 8'b00000010, SE = 8'b10011110;
  localparam logic [7:0] SB = 8'b00000000;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] value = '0;
  logic        load  = 1'b0;

  logic       busy1, done1, busy0, done0;
  logic [0:7] a0, a1, a2, a3, b0, b1, b2, b3;
  logic [31:0] pat1, pat0;

  int n_chk = 0, n_err = 0, n_exp = 0;
  int dcnt1 = 0, dcnt0 = 0;

  display_formatter #(.LZB(1'b1)) u_lzb1 (
    .Clock(Clock), .Reset(Reset), .value(value), .load(load),
    .busy(busy1), .done(done1), .oct0(a0), .oct1(a1), .oct2(a2), .oct3(a3));

  display_formatter #(.LZB(1'b0)) u_lzb0 (
    .Clock(Clock), .Reset(Reset), .value(value), .load(load),
    .busy(busy0), .done(done0), .oct0(b0), .oct1(b1), .oct2(b2), .oct3(b3));

  assign pat1 = {a0, a1, a2, a3};
  assign pat0 = {b0, b1, b2, b3};

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (done1) dcnt1++;
    if (done0) dcnt0++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [7:0] sg(input int d);
    case (d)
      0: sg = S0; 1: sg = S1; 2: sg = S2; 3: sg = S3; 4: sg = S4;
      5: sg = S5; 6: sg = S6; 7: sg = S7; 8: sg = S8; default: sg = S9;
    endcase
  endfunction

  // Reference model using decimal arithmetic
  function automatic logic [31:0] ref_pat(input logic [15:0] v, input bit lzb);
    int sv, m, k;
    int d[4];
    bit neg, ovf;
    logic [7:0] p[4];
    sv  = $signed(v);
    neg = (sv < 0);
    m   = neg ? -sv : sv;
    ovf = neg ? (m > 999) : (m > 9999);
    d[0] = (m / 1000) % 10; d[1] = (m / 100) % 10; d[2] = (m / 10) % 10; d[3] = m % 10;
    for (int i = 0; i < 4; i++) p[i] = sg(d[i]);
    if (ovf) begin
      for (int i = 0; i < 4; i++) p[i] = SE;
    end else if (!neg) begin
      if (lzb) begin
        k = 0;
        while (k < 3 && d[k] == 0) begin p[k] = SB; k++; end
      end
    end else if (!lzb) begin
      p[0] = SM;
    end else begin
      k = 0;
      while (k < 3 && d[k] == 0) k++;
      for (int i = 0; i < k; i++) p[i] = (i == k - 1) ? SM : SB;
    end
    return {p[0], p[1], p[2], p[3]};
  endfunction

  // One conversion with fixed-latency checks on both instances
  task automatic run(input string tag, input logic [15:0] v,
                     input logic [31:0] e1, input logic [31:0] e0);
    logic [31:0] old1;
    old1  = pat1;
    value = v;
    load  = 1'b1;
    tick();                           // edge N
    load  = 1'b0;
    chk({tag, ".busyN"}, busy1, 1'b1);
    repeat (16) tick();               // edge N+16
    chk({tag, ".busy16"}, {busy1, busy0}, 2'b11);
    chk({tag, ".hold16"}, pat1, old1);
    tick();                           // edge N+17
    chk({tag, ".busy17"}, {busy1, busy0}, 2'b00);
    chk({tag, ".done17"}, {done1, done0}, 2'b11);
    chk({tag, ".lzb1"}, pat1, e1);
    chk({tag, ".lzb0"}, pat0, e0);
    tick();                           // edge N+18
    chk({tag, ".done18"}, {done1, done0}, 2'b00);
    n_exp++;
  endtask

  initial begin
    logic [15:0] v;
    int d1;

    // Reset state
    tick(); tick();
    Reset = 1'b0;
    chk("rst.busy", {busy1, busy0}, 2'b00);
    chk("rst.done", {done1, done0}, 2'b00);
    chk("rst.pat1", pat1, 32'h0);
    chk("rst.pat0", pat0, 32'h0);

    // Directed vectors
    run("v1234",  16'd1234,  {S1, S2, S3, S4}, {S1, S2, S3, S4});
    run("v0",     16'd0,     {SB, SB, SB, S0}, {S0, S0, S0, S0});
    run("vm7",    -16'sd7,   {SB, SB, SM, S7}, {SM, S0, S0, S7});
    run("v10000", 16'd10000, {SE, SE, SE, SE}, {SE, SE, SE, SE});
    run("vm1000", -16'sd1000, {SE, SE, SE, SE}, {SE, SE, SE, SE});
    run("vm32768", 16'h8000, {SE, SE, SE, SE}, {SE, SE, SE, SE});
    run("v32767", 16'd32767, {SE, SE, SE, SE}, {SE, SE, SE, SE});
    run("v9999",  16'd9999,  {S9, S9, S9, S9}, {S9, S9, S9, S9});
    run("vm999",  -16'sd999, {SM, S9, S9, S9}, {SM, S9, S9, S9});
    run("vm40",   -16'sd40,  {SB, SM, S4, S0}, {SM, S0, S4, S0});
    run("v305",   16'd305,   {SB, S3, S0, S5}, {S0, S3, S0, S5});

    // Load during a conversion is ignored
    d1 = dcnt1;
    value = 16'd42; load = 1'b1; tick(); load = 1'b0;       // N
    repeat (4) tick();                                       // N+4
    value = 16'd999; load = 1'b1; tick(); load = 1'b0;      // N+5
    value = 16'd0;
    repeat (12) tick();                                      // N+17
    chk("ign.pat1", pat1, {SB, SB, S4, S2});
    chk("ign.done", done1, 1'b1);
    repeat (25) tick();
    chk("ign.dcnt", dcnt1, d1 + 1);
    chk("ign.busy", busy1, 1'b0);
    chk("ign.hold", pat1, {SB, SB, S4, S2});
    n_exp++;

    // Reset mid-conversion aborts and blanks
    d1 = dcnt1;
    value = 16'd5555; load = 1'b1; tick(); load = 1'b0;     // N
    repeat (7) tick();                                       // N+7
    Reset = 1'b1; tick(); Reset = 1'b0;                      // N+8
    chk("abort.busy", busy1, 1'b0);
    chk("abort.pat", pat1, 32'h0);
    repeat (15) tick();
    chk("abort.dcnt", dcnt1, d1);
    chk("abort.pat2", pat0, 32'h0);
    run("v5555", 16'd5555, {S5, S5, S5, S5}, {S5, S5, S5, S5});

    // Reset and load on the same edge: load dropped
    d1 = dcnt1;
    Reset = 1'b1; load = 1'b1; value = 16'd1234; tick();
    Reset = 1'b0; load = 1'b0;
    chk("rl.busy", busy1, 1'b0);
    repeat (20) tick();
    chk("rl.pat", pat1, 32'h0);
    chk("rl.dcnt", dcnt1, d1);

    // Back-to-back with load held high
    value = 16'd77; load = 1'b1; tick();                     // N
    repeat (17) tick();                                      // N+17
    chk("b2b.busy17", busy1, 1'b0);
    chk("b2b.pat1", pat1, {SB, SB, S7, S7});
    value = 16'd88; tick();                                  // N+18
    load = 1'b0;
    chk("b2b.busy18", busy1, 1'b1);
    repeat (17) tick();
    chk("b2b.pat2", pat1, {SB, SB, S8, S8});
    chk("b2b.pat2z", pat0, {S0, S0, S8, S8});
    tick();
    n_exp += 2;

    // Random values against the model
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) v = 16'($urandom);
      else            v = 16'($signed(32'($urandom_range(0, 19998))) - 9999);
      run($sformatf("rnd%0d", i), v, ref_pat(v, 1'b1), ref_pat(v, 1'b0));
    end

    chk("dcnt1", dcnt1, n_exp);
    chk("dcnt0", dcnt0, n_exp);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
